// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the five-stage CPU pipeline registers:
// payload widths, the IF/ID payload layout, the NOP encoding and the
// occupancy encoding used by the skid-buffered stage register.
package cpu_pipe_pkg;

    // Payload widths of the inter-stage registers.
    localparam int unsigned IFID_W  = 64;
    localparam int unsigned IDEX_W  = 128;
    localparam int unsigned EXMEM_W = 96;

    // An all-zero instruction word is a MIPS NOP (sll $0,$0,0).
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // IF/ID payload: next sequential PC and the fetched instruction.
    typedef struct packed {
        logic [31:0] pcadd4;
        logic [31:0] inst;
    } ifid_payload_t;

    // Occupancy of the skid-buffered stage register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones,
// and is cleared only by reset.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == {CNT_W{1'b1}});

    // Count enabled cycles until the counter reaches all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_max) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble
// insertion. SKID=0 gives a single register with a combinational in_ready;
// SKID=1 adds a skid register so that in_ready comes straight from a flop.
//
// Optional build macro PIPE_STAGE_PERF_EN adds saturating stall, bubble
// and flush counters (CNT_W bits each) on extra output ports.
//
// Skid-mode states:
//   state    | meaning
//   ST_EMPTY | main and skid empty, in_ready=1
//   ST_BUSY  | main holds an entry, skid empty, in_ready=1
//   ST_FULL  | main and skid both hold entries, in_ready=0
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W       = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = {DATA_W{1'b0}},
    parameter int unsigned       SKID         = 0
`ifdef PIPE_STAGE_PERF_EN
    , parameter int unsigned     CNT_W        = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] bubble_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);

    logic              w_in_ready;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_data;

    if (SKID == 0) begin : g_single

        logic              r_valid;
        logic [DATA_W-1:0] r_data;
        logic              w_ready;

        assign w_ready = !rst && (!r_valid || out_ready);

        // Load whenever the slot frees up; an absent input loads a bubble so
        // the data register never keeps a stale payload. Flush wins.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= BUBBLE_VALUE;
            end else if (flush) begin
                r_valid <= 1'b0;
                r_data  <= BUBBLE_VALUE;
            end else if (w_ready) begin
                r_valid <= in_valid;
                r_data  <= in_valid ? in_data : BUBBLE_VALUE;
            end
        end

        assign w_in_ready  = w_ready;
        assign w_out_valid = r_valid;
        assign w_out_data  = r_data;

    end else begin : g_skid

        stage_state_e      r_state;
        stage_state_e      w_state_nxt;
        logic [DATA_W-1:0] r_main;
        logic [DATA_W-1:0] r_skid;
        logic [DATA_W-1:0] w_main_nxt;
        logic [DATA_W-1:0] w_skid_nxt;
        logic              r_in_ready;
        logic              w_accept;

        // r_in_ready is zero in ST_FULL, so nothing can be accepted there.
        assign w_accept = in_valid && r_in_ready;

        // Next occupancy and register contents; empty slots always hold the
        // bubble value, and flush overrides everything else.
        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && out_ready) begin
                        w_main_nxt = in_data;
                    end else if (w_accept) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = ST_FULL;
                    end else if (out_ready) begin
                        w_main_nxt  = BUBBLE_VALUE;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_VALUE;
                        w_state_nxt = ST_BUSY;
                    end
                end
                default: begin
                    w_main_nxt  = BUBBLE_VALUE;
                    w_skid_nxt  = BUBBLE_VALUE;
                    w_state_nxt = ST_EMPTY;
                end
            endcase
            if (flush) begin
                w_main_nxt  = BUBBLE_VALUE;
                w_skid_nxt  = BUBBLE_VALUE;
                w_state_nxt = ST_EMPTY;
            end
        end

        // State and data registers; in_ready is registered from the next
        // state, so it stays low through reset and rises on the first edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= ST_EMPTY;
                r_main     <= BUBBLE_VALUE;
                r_skid     <= BUBBLE_VALUE;
                r_in_ready <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_main     <= w_main_nxt;
                r_skid     <= w_skid_nxt;
                r_in_ready <= (w_state_nxt != ST_FULL);
            end
        end

        assign w_in_ready  = r_in_ready;
        assign w_out_valid = (r_state != ST_EMPTY);
        assign w_out_data  = r_main;

    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_data;

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall_en;
    logic w_bubble_en;

    assign w_stall_en  = w_out_valid && !out_ready;
    assign w_bubble_en = !w_out_valid;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_stall_en),
        .o_cnt (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_bubble_en),
        .o_cnt (bubble_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (flush),
        .o_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, each with
// its own upstream source queue. A FIFO model (capacity 1 or 2) predicts
// in_ready/out_valid/out_data every cycle; directed scenarios add literal
// expectations on the transfers seen leaving each instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  flush;
    logic [63:0] in_data  [2];
    logic [63:0] out_data [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base;

    logic [63:0] src_q   [2][$];
    logic [63:0] mq      [2][$];
    logic [63:0] out_log [2][$];
    int          out_cyc [2][$];
    bit          armed = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]  st0, bb0, fl0;
    logic [31:0] st1, bb1, fl1;
    logic [31:0] m_cnt [2][3];
    logic [31:0] d0 [3];
    logic [31:0] m0 [3];
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (64),
        .SKID   (0)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W (4)
`endif
    ) u_s0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt  (st0)
        , .bubble_cnt (bb0)
        , .flush_cnt  (fl0)
`endif
    );

    pipe_stage_reg #(
        .DATA_W (64),
        .SKID   (1)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W (32)
`endif
    ) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt  (st1)
        , .bubble_cnt (bb1)
        , .flush_cnt  (fl1)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO view: SKID=0 holds one entry and frees up when the consumer takes
    // it; SKID=1 holds two and its ready reflects occupancy at cycle start.
    function automatic logic model_rdy(input int d);
        if (rst) return 1'b0;
        if (d == 0) return (mq[0].size() == 0) || out_ready[0];
        return armed && (mq[1].size() < 2);
    endfunction

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int d);
        logic [31:0] mx;
        mx = (d == 0) ? 32'h0000_000F : 32'hFFFF_FFFF;
        return (v == mx) ? v : v + 32'd1;
    endfunction
`endif

    // Reference model update at each clock edge (or reset).
    always @(posedge clk or posedge rst) begin
        logic acc;
        logic pop;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                mq[d].delete();
`ifdef PIPE_STAGE_PERF_EN
                for (int k = 0; k < 3; k++) m_cnt[d][k] = 32'd0;
`endif
            end
            armed = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                acc = in_valid[d] && model_rdy(d);
                pop = (mq[d].size() > 0) && out_ready[d];
`ifdef PIPE_STAGE_PERF_EN
                if (mq[d].size() > 0 && !out_ready[d]) m_cnt[d][0] = sat_inc(m_cnt[d][0], d);
                if (mq[d].size() == 0) m_cnt[d][1] = sat_inc(m_cnt[d][1], d);
                if (flush[d]) m_cnt[d][2] = sat_inc(m_cnt[d][2], d);
`endif
                if (pop) void'(mq[d].pop_front());
                if (acc && !flush[d]) mq[d].push_back(in_data[d]);
                if (flush[d]) mq[d].delete();
            end
            armed = 1'b1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready[%0d]", d), 64'(in_ready[d]), 64'(model_rdy(d)));
            chk($sformatf("out_valid[%0d]", d), 64'(out_valid[d]), 64'(mq[d].size() > 0));
            chk($sformatf("out_data[%0d]", d), out_data[d], (mq[d].size() > 0) ? mq[d][0] : 64'h0);
            if (out_valid[d] && out_ready[d]) begin
                out_log[d].push_back(out_data[d]);
                out_cyc[d].push_back(cyc);
            end
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt[0]",  64'(st0), 64'(m_cnt[0][0]));
        chk("bubble_cnt[0]", 64'(bb0), 64'(m_cnt[0][1]));
        chk("flush_cnt[0]",  64'(fl0), 64'(m_cnt[0][2]));
        chk("stall_cnt[1]",  64'(st1), 64'(m_cnt[1][0]));
        chk("bubble_cnt[1]", 64'(bb1), 64'(m_cnt[1][1]));
        chk("flush_cnt[1]",  64'(fl1), 64'(m_cnt[1][2]));
`endif
    end

    task automatic refresh();
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = (src_q[d].size() > 0);
            in_data[d]  = (src_q[d].size() > 0) ? src_q[d][0] : 64'h0;
        end
    endtask

    // One clock: note upstream transfers mid-cycle, then advance the sources.
    task automatic tick();
        logic [1:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            if (acc[d]) void'(src_q[d].pop_front());
        refresh();
    endtask

    task automatic drain(input int d);
        int g;
        g = 0;
        while ((src_q[d].size() > 0 || out_valid[d]) && g < 40) begin
            tick();
            g++;
        end
        chk($sformatf("drain_timeout[%0d]", d), 64'(g >= 40), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        flush     = '0;
        in_data[0] = 64'h0;
        in_data[1] = 64'h0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), 64'(out_valid[d]), 64'd0);
            chk($sformatf("rst_out_data[%0d]", d), out_data[d], 64'h0);
            chk($sformatf("rst_in_ready[%0d]", d), 64'(in_ready[d]), 64'd0);
        end
        rst = 1'b0;
        out_ready = 2'b11;
        tick();
        tick();

        // Back-to-back stream of 8 entries with the consumer always ready.
        for (int d = 0; d < 2; d++) begin
            base = out_log[d].size();
            for (int i = 0; i < 8; i++) src_q[d].push_back(64'h0000_0004_2002_0001 + 64'(i));
            refresh();
            drain(d);
            chk($sformatf("stream_count[%0d]", d), 64'(out_log[d].size() - base), 64'd8);
            if (out_log[d].size() - base == 8) begin
                for (int i = 0; i < 8; i++)
                    chk($sformatf("stream_data[%0d][%0d]", d, i), out_log[d][base+i],
                        64'h0000_0004_2002_0001 + 64'(i));
                for (int i = 1; i < 8; i++)
                    chk($sformatf("stream_gap[%0d][%0d]", d, i),
                        64'(out_cyc[d][base+i] - out_cyc[d][base+i-1]), 64'd1);
            end
        end

        // Hazard stall: three cycles of backpressure while A then B are offered.
        for (int d = 0; d < 2; d++) begin
            base = out_log[d].size();
            out_ready[d] = 1'b0;
            src_q[d].push_back(64'hA);
            src_q[d].push_back(64'hB);
            refresh();
            #1 chk($sformatf("stall_rdy_c0[%0d]", d), 64'(in_ready[d]), 64'd1);
            tick();
            #1 chk($sformatf("stall_rdy_c1[%0d]", d), 64'(in_ready[d]), (d == 1) ? 64'd1 : 64'd0);
            tick();
            #1 chk($sformatf("stall_rdy_c2[%0d]", d), 64'(in_ready[d]), 64'd0);
            tick();
            out_ready[d] = 1'b1;
            drain(d);
            chk($sformatf("stall_count[%0d]", d), 64'(out_log[d].size() - base), 64'd2);
            if (out_log[d].size() - base == 2) begin
                chk($sformatf("stall_first[%0d]", d), out_log[d][base], 64'hA);
                chk($sformatf("stall_second[%0d]", d), out_log[d][base+1], 64'hB);
            end
        end

        // Flush priority: held 5 and incoming 6 must both vanish.
        for (int d = 0; d < 2; d++) begin
            base = out_log[d].size();
            out_ready[d] = 1'b0;
            src_q[d].push_back(64'h5);
            refresh();
            tick();
            src_q[d].push_back(64'h6);
            refresh();
            flush[d] = 1'b1;
            tick();
            flush[d] = 1'b0;
            src_q[d].delete();
            refresh();
            #1;
            chk($sformatf("flush_valid[%0d]", d), 64'(out_valid[d]), 64'd0);
            chk($sformatf("flush_data[%0d]", d), out_data[d], 64'h0);
            out_ready[d] = 1'b1;
            repeat (3) tick();
            chk($sformatf("flush_nothing_out[%0d]", d), 64'(out_log[d].size() - base), 64'd0);
        end

        // Flush in the same cycle as a completing downstream transfer.
        for (int d = 0; d < 2; d++) begin
            base = out_log[d].size();
            out_ready[d] = 1'b0;
            src_q[d].push_back(64'h7);
            refresh();
            tick();
            out_ready[d] = 1'b1;
            flush[d] = 1'b1;
            tick();
            flush[d] = 1'b0;
            #1;
            chk($sformatf("flushxfer_valid[%0d]", d), 64'(out_valid[d]), 64'd0);
            chk($sformatf("flushxfer_count[%0d]", d), 64'(out_log[d].size() - base), 64'd1);
            if (out_log[d].size() - base == 1)
                chk($sformatf("flushxfer_data[%0d]", d), out_log[d][base], 64'h7);
            tick();
        end

`ifdef PIPE_STAGE_PERF_EN
        // Nine edges on the skid instance: 5 stalls, 3 bubbles, 2 flushes.
        out_ready[1] = 1'b0;
        d0[0] = st1; d0[1] = bb1; d0[2] = fl1;
        for (int k = 0; k < 3; k++) m0[k] = m_cnt[1][k];
        src_q[1].push_back(64'h11);
        refresh();
        tick();
        tick();
        tick();
        tick();
        flush[1] = 1'b1;
        tick();
        src_q[1].push_back(64'h12);
        refresh();
        tick();
        flush[1] = 1'b0;
        src_q[1].push_back(64'h13);
        refresh();
        tick();
        tick();
        out_ready[1] = 1'b1;
        tick();
        chk("perf_stall",  64'(st1 - d0[0]), 64'd5);
        chk("perf_bubble", 64'(bb1 - d0[1]), 64'd3);
        chk("perf_flush",  64'(fl1 - d0[2]), 64'd2);
        chk("perf_model_stall",  64'(m_cnt[1][0] - m0[0]), 64'd5);
        chk("perf_model_bubble", 64'(m_cnt[1][1] - m0[1]), 64'd3);
        chk("perf_model_flush",  64'(m_cnt[1][2] - m0[2]), 64'd2);
        drain(1);

        // 20 stall cycles saturate the 4-bit counter.
        out_ready[0] = 1'b0;
        src_q[0].push_back(64'h21);
        refresh();
        repeat (21) tick();
        chk("perf_stall_sat", 64'(st0), 64'hF);
        out_ready[0] = 1'b1;
        drain(0);
`endif

        // Asynchronous reset while the skid instance is full.
        out_ready[1] = 1'b0;
        src_q[1].push_back(64'hC);
        src_q[1].push_back(64'hD);
        refresh();
        tick();
        tick();
        #1;
        chk("full_valid", 64'(out_valid[1]), 64'd1);
        chk("full_in_ready", 64'(in_ready[1]), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid[1]), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready[1]), 64'd0);
        chk("async_rst_data", out_data[1], 64'h0);
        chk("async_rst_in_ready_s0", 64'(in_ready[0]), 64'd0);
        src_q[0].delete();
        src_q[1].delete();
        refresh();
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready = 2'b11;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the five-stage CPU, replacing the fixed IF/ID latch. It carries an arbitrary payload, such as {pcadd4, inst}, with a valid/ready handshake. It supports hazard stalls through downstream backpressure and branch flushes, and inserts a configurable bubble value. An optional skid mode registers the upstream ready signal for timing closure without losing throughput.

Parameters:
DATA_W, 64, payload width in bits (IF/ID use: {pcadd4[31:0], inst[31:0]}).
BUBBLE_VALUE, {DATA_W{1'b0}}, out_data driven whenever out_valid=0 (all-zero = MIPS NOP).
SKID, 0, 0 = single register with combinational in_ready; 1 = main plus skid register with registered in_ready.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
flush  input  1  discard all held and incoming entries (branch taken or exception)
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  entry held for downstream
out_ready  input  1  downstream accepts; 0 = hazard stall
out_data  output  DATA_W  held payload; BUBBLE_VALUE when out_valid=0

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=BUBBLE_VALUE, skid empty. in_ready=0 while rst=1.
- Transfer rules: upstream transfer = in_valid & in_ready. Downstream transfer = out_valid & out_ready. Latency is 1 cycle from input transfer to out_valid.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - At the clock edge, if in_ready: out_valid <= in_valid, and out_data <= in_valid ? in_data : BUBBLE_VALUE.
  - Otherwise hold both outputs.
- SKID=1:
  - States: EMPTY (main empty), BUSY (main full, skid empty), FULL (main and skid full).
  - in_ready is a flop output, equal to 1 in EMPTY and BUSY, 0 in FULL.
  - EMPTY: on accept, main <= in_data and move to BUSY.
  - BUSY, accept with out_ready: main <= in_data and stay in BUSY.
  - BUSY, accept without out_ready: skid <= in_data and move to FULL.
  - BUSY, out_ready without accept: move to EMPTY.
  - FULL, out_ready: main <= skid, skid cleared, move to BUSY. No accept is possible in FULL.
  - Ordering and throughput: strict FIFO, no entry is dropped or duplicated, and one transfer per cycle is sustained.
- flush (both modes):
  - Highest priority, synchronous: at the next edge all entries are invalidated, out_data=BUBBLE_VALUE, and the state goes to EMPTY.
  - An input transfer in the flush cycle is discarded.
  - in_ready is still computed normally during the flush cycle, so upstream treats the entry as consumed.
- Simultaneous flush and out_ready: the downstream transfer of the currently held entry completes in that cycle. Only the state is cleared.
- Reset mid-operation: all entries are lost immediately, with no handshake completion.
- out_data must never show stale payload while out_valid=0.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined: adds outputs stall_cnt, bubble_cnt and flush_cnt, each CNT_W wide.
  - stall_cnt increments on out_valid & !out_ready.
  - bubble_cnt increments on !out_valid.
  - flush_cnt increments on flush.
  - All three saturate at all-ones, are cleared only by rst, and are not affected by flush.
- When undefined: these ports and their logic are absent, and the handshake behaviour is identical.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - the typedef for the IF/ID payload struct {pcadd4, inst};
  - constants IFID_W=64, IDEX_W and EXMEM_W;
  - constant NOP_INST=32'h0000_0000;
  - the state encoding for EMPTY/BUSY/FULL.
- Sub-module: pipe_sat_counter (parametrised CNT_W saturating counter with enable), instantiated three times under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset then stream, SKID=0/1: hold rst=1 for 3 cycles, then feed 8 back-to-back entries with out_ready=1, in_data=64'h0000_0004_2002_0001 upward. Required: out_valid=1 from the cycle after the first accept, and the same 8 values come out in order with no gap.
- Hazard stall: drive out_ready=0 for 3 cycles while in_valid=1 with 64'hA, then 64'hB.
  - SKID=0: in_ready drops in the same cycle.
  - SKID=1: exactly one extra entry is absorbed, then in_ready=0.
  - In both modes, after release the output is A then B, each exactly once.
- Flush priority: hold entry 64'h5 with out_ready=0, and assert flush together with in_valid=1 carrying 64'h6. Required: next cycle out_valid=0 and out_data=64'h0; neither 5 nor 6 ever appears.
- Flush with a completing transfer: out_valid=1, out_ready=1 and flush=1 in the same cycle. Required: the current entry counts as transferred, and the stage is empty next cycle.
- Async reset mid-FULL (SKID=1): assert rst between clock edges. Required: out_valid=0 and in_ready=0 immediately, without waiting for a clock edge.
- PIPE_STAGE_PERF_EN: run 5 stall cycles, 3 bubble cycles and 2 flushes. Required: stall_cnt=5, bubble_cnt=3 (not counting post-flush bubbles separately), flush_cnt=2. With CNT_W=4, forcing 20 stalls gives stall_cnt=4'hF.
